// File: rtl/avr_cpu_sequencer_pkg.sv
// avr_cpu_sequencer_pkg: sequencer state encodings, predecode match masks and cycle counts
package avr_cpu_sequencer_pkg;
  localparam logic [2:0] SEQ_FETCH1 = 3'd0;
  localparam logic [2:0] SEQ_FETCH2 = 3'd1;
  localparam logic [2:0] SEQ_EXEC   = 3'd2;
  localparam logic [2:0] SEQ_SKIP1  = 3'd3;
  localparam logic [2:0] SEQ_SKIP2  = 3'd4;
  typedef struct packed {
    logic [15:0] mask;
    logic [15:0] val;
  } match_t;
  localparam match_t PREDEC_RJMP   = '{16'hF000, 16'hC000};
  localparam match_t PREDEC_RCALL  = '{16'hF000, 16'hD000};
  localparam match_t PREDEC_IJMP   = '{16'hFFFF, 16'h9409};
  localparam match_t PREDEC_ICALL  = '{16'hFFFF, 16'h9509};
  localparam match_t PREDEC_RET    = '{16'hFFFF, 16'h9508};
  localparam match_t PREDEC_RETI   = '{16'hFFFF, 16'h9518};
  localparam match_t PREDEC_JMP    = '{16'hFE0E, 16'h940C};
  localparam match_t PREDEC_CALL   = '{16'hFE0E, 16'h940E};
  localparam match_t PREDEC_LDS    = '{16'hFE0F, 16'h9000};
  localparam match_t PREDEC_STS    = '{16'hFE0F, 16'h9200};
  localparam match_t PREDEC_LPM0   = '{16'hFFFF, 16'h95C8};
  localparam match_t PREDEC_LPMZ   = '{16'hFE0E, 16'h9004};
  localparam match_t PREDEC_SBI    = '{16'hFF00, 16'h9A00};
  localparam match_t PREDEC_CBI    = '{16'hFF00, 16'h9800};
  localparam match_t PREDEC_BRANCH = '{16'hF800, 16'hF000};
  localparam match_t PREDEC_CPSE   = '{16'hFC00, 16'h1000};
  localparam match_t PREDEC_SBRX   = '{16'hFC08, 16'hFC00};
  localparam match_t PREDEC_SBIX   = '{16'hFD00, 16'h9900};
  localparam logic [3:0] NCYC_1 = 4'd1;
  localparam logic [3:0] NCYC_2 = 4'd2;
  localparam logic [3:0] NCYC_3 = 4'd3;
  localparam logic [3:0] NCYC_4 = 4'd4;
  function automatic logic hit(input logic [15:0] w, input match_t m);
    return (w & m.mask) == m.val;
  endfunction
endpackage

// File: rtl/avr_cpu_sequencer_predecode.sv
// avr_cpu_predecode: classifies a first instruction word into length, cycle count and control class
import avr_cpu_sequencer_pkg::*;
module avr_cpu_predecode #(
  parameter int PC_WIDTH = 16
) (
  input  logic [15:0] word,
  output logic        two_word,
  output logic [3:0]  ncyc,
  output logic        is_skip,
  output logic        is_branch,
  output logic        changes_pc
);
  logic rjmp, rcall, ijmp, icall, ret, reti, jmp, call, lds, sts, lpm, sbi, cbi, ext;
  logic [3:0] base;
  always_comb begin
    rjmp  = hit(word, PREDEC_RJMP);
    rcall = hit(word, PREDEC_RCALL);
    ijmp  = hit(word, PREDEC_IJMP);
    icall = hit(word, PREDEC_ICALL);
    ret   = hit(word, PREDEC_RET);
    reti  = hit(word, PREDEC_RETI);
    jmp   = hit(word, PREDEC_JMP);
    call  = hit(word, PREDEC_CALL);
    lds   = hit(word, PREDEC_LDS);
    sts   = hit(word, PREDEC_STS);
    lpm   = hit(word, PREDEC_LPM0) || hit(word, PREDEC_LPMZ);
    sbi   = hit(word, PREDEC_SBI);
    cbi   = hit(word, PREDEC_CBI);
    // wide program counters push a third return-address byte
    ext   = (PC_WIDTH > 16) && (rcall || icall || call || ret || reti);
    base  = (call || ret || reti) ? NCYC_4 :
            (jmp || lpm || rcall || icall) ? NCYC_3 :
            (rjmp || ijmp || lds || sts || sbi || cbi) ? NCYC_2 : NCYC_1;
    ncyc       = base + {3'b000, ext};
    two_word   = jmp || call || lds || sts;
    is_branch  = hit(word, PREDEC_BRANCH);
    is_skip    = hit(word, PREDEC_CPSE) || hit(word, PREDEC_SBRX) || hit(word, PREDEC_SBIX);
    changes_pc = rjmp || rcall || ijmp || icall || ret || reti || jmp || call;
  end
endmodule

// File: rtl/avr_cpu_sequencer.sv
// avr_cpu_sequencer: instruction register, per-instruction cycle counter and skip squashing
import avr_cpu_sequencer_pkg::*;
module avr_cpu_sequencer #(
  parameter int PC_WIDTH = 16,
  parameter int CYC_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      fetch_word,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             skip_taken,
  output logic [15:0]      opcode,
  output logic [15:0]      opcode_ext,
  output logic [CYC_W-1:0] cycle,
  output logic             exec_valid,
  output logic             last_cycle,
  output logic             pc_inc
);
  logic [2:0] st;
  logic [3:0] o_ncyc, f_ncyc;
  logic last_q, o_two, o_skip, o_branch, o_chg, f_two, f_skip, f_branch, f_chg;
  logic fire, start, pc_chg, unused_ok;
  avr_cpu_predecode #(.PC_WIDTH(PC_WIDTH)) u_pre_op (
    .word(opcode), .two_word(o_two), .ncyc(o_ncyc), .is_skip(o_skip),
    .is_branch(o_branch), .changes_pc(o_chg)
  );
  avr_cpu_predecode #(.PC_WIDTH(PC_WIDTH)) u_pre_fetch (
    .word(fetch_word), .two_word(f_two), .ncyc(f_ncyc), .is_skip(f_skip),
    .is_branch(f_branch), .changes_pc(f_chg)
  );
  always_comb begin
    unused_ok   = ^{o_two, f_skip, f_branch, f_chg};
    // a taken branch on cycle 0 stretches into a second cycle
    last_cycle  = last_q && !(o_branch && cycle == '0 && branch_taken);
    pc_chg      = o_chg || (o_branch && cycle != '0);
    fetch_ready = !stall && (st != SEQ_EXEC || (last_cycle && !o_skip && !pc_chg));
    fire        = fetch_valid && fetch_ready;
    pc_inc      = fire;
    start       = fire && (st == SEQ_FETCH1 || st == SEQ_EXEC);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st         <= SEQ_FETCH1;
      opcode     <= '0;
      opcode_ext <= '0;
      cycle      <= '0;
      exec_valid <= 1'b0;
      last_q     <= 1'b0;
    end else if (!stall) begin
      if (start) begin
        opcode     <= fetch_word;
        opcode_ext <= '0;
        st         <= f_two ? SEQ_FETCH2 : SEQ_EXEC;
        exec_valid <= !f_two;
        cycle      <= '0;
        last_q     <= !f_two && f_ncyc == NCYC_1;
      end else if (st == SEQ_FETCH2) begin
        if (fire) begin
          opcode_ext <= fetch_word;
          st         <= SEQ_EXEC;
          exec_valid <= 1'b1;
          last_q     <= o_ncyc == NCYC_1;
        end
      end else if (st == SEQ_EXEC) begin
        if (!last_cycle) begin
          cycle  <= cycle + CYC_W'(1);
          last_q <= o_branch || (cycle + CYC_W'(1)) == CYC_W'(o_ncyc - NCYC_1);
        end else begin
          st         <= (o_skip && skip_taken) ? SEQ_SKIP1 : SEQ_FETCH1;
          exec_valid <= 1'b0;
          cycle      <= '0;
          last_q     <= 1'b0;
        end
      end else if (fire) begin
        st <= (st == SEQ_SKIP1 && f_two) ? SEQ_SKIP2 : SEQ_FETCH1;
      end
    end
endmodule

// File: tb/tb_avr_cpu_sequencer.sv
// tb_avr_cpu_sequencer: directed checks of the sequencer at 16- and 22-bit program counter widths
module tb_avr_cpu_sequencer;
  logic clk = 1'b0;
  logic rst_n, fetch_valid, stall, branch_taken, skip_taken;
  logic [15:0] fetch_word;
  logic fetch_ready, exec_valid, last_cycle, pc_inc;
  logic [15:0] opcode, opcode_ext;
  logic [2:0] cycle;
  logic fetch_ready_w, exec_valid_w, last_cycle_w, pc_inc_w;
  logic [15:0] opcode_w, opcode_ext_w;
  logic [2:0] cycle_w;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  avr_cpu_sequencer #(.PC_WIDTH(16), .CYC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_word(fetch_word), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .stall(stall), .branch_taken(branch_taken),
    .skip_taken(skip_taken), .opcode(opcode), .opcode_ext(opcode_ext), .cycle(cycle),
    .exec_valid(exec_valid), .last_cycle(last_cycle), .pc_inc(pc_inc)
  );
  avr_cpu_sequencer #(.PC_WIDTH(22), .CYC_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .fetch_word(fetch_word), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready_w), .stall(stall), .branch_taken(branch_taken),
    .skip_taken(skip_taken), .opcode(opcode_w), .opcode_ext(opcode_ext_w), .cycle(cycle_w),
    .exec_valid(exec_valid_w), .last_cycle(last_cycle_w), .pc_inc(pc_inc_w)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic v, input logic [15:0] w);
    fetch_valid = v;
    fetch_word  = w;
    #1;
  endtask
  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_word = '0;
    stall = 1'b0; branch_taken = 1'b0; skip_taken = 1'b0;
    #2;
    chk("rst_opcode", opcode, 16'h0000);
    chk("rst_ext", opcode_ext, 16'h0000);
    chk("rst_cycle", {13'b0, cycle}, 16'd0);
    chk("rst_exec", {15'b0, exec_valid}, 16'd0);
    chk("rst_last", {15'b0, last_cycle}, 16'd0);
    chk("rst_pcinc", {15'b0, pc_inc}, 16'd0);
    chk("rst_ready", {15'b0, fetch_ready}, 16'd1);
    tick; tick;
    rst_n = 1'b1;
    // three back-to-back ADDs
    feed(1'b1, 16'h0C12);
    chk("add0_pcinc", {15'b0, pc_inc}, 16'd1);
    tick;
    feed(1'b1, 16'h0C34);
    chk("add1_op", opcode, 16'h0C12);
    chk("add1_exec", {15'b0, exec_valid}, 16'd1);
    chk("add1_cyc", {13'b0, cycle}, 16'd0);
    chk("add1_pcinc", {15'b0, pc_inc}, 16'd1);
    tick;
    feed(1'b1, 16'h0C56);
    chk("add2_op", opcode, 16'h0C34);
    chk("add2_exec", {15'b0, exec_valid}, 16'd1);
    chk("add2_pcinc", {15'b0, pc_inc}, 16'd1);
    tick;
    feed(1'b0, 16'h0000);
    chk("add3_op", opcode, 16'h0C56);
    chk("add3_exec", {15'b0, exec_valid}, 16'd1);
    chk("add3_cyc", {13'b0, cycle}, 16'd0);
    chk("add3_pcinc", {15'b0, pc_inc}, 16'd0);
    tick;
    chk("add_idle_exec", {15'b0, exec_valid}, 16'd0);
    // CALL at both program counter widths
    feed(1'b1, 16'h940E);
    tick;
    feed(1'b1, 16'h0123);
    chk("call_f2_exec", {15'b0, exec_valid}, 16'd0);
    chk("call_f2_pcinc", {15'b0, pc_inc}, 16'd1);
    tick;
    feed(1'b0, 16'h0000);
    chk("call_ext", opcode_ext, 16'h0123);
    chk("call_ext_w", opcode_ext_w, 16'h0123);
    for (int i = 0; i < 5; i++) begin
      chk("call_w_cyc", {13'b0, cycle_w}, 16'(i));
      chk("call_w_last", {15'b0, last_cycle_w}, 16'(i == 4));
      chk("call_w_ready", {15'b0, fetch_ready_w}, 16'd0);
      if (i < 4) begin
        chk("call_cyc", {13'b0, cycle}, 16'(i));
        chk("call_last", {15'b0, last_cycle}, 16'(i == 3));
        chk("call_ready", {15'b0, fetch_ready}, 16'd0);
      end else begin
        chk("call_done", {15'b0, exec_valid}, 16'd0);
      end
      tick;
    end
    chk("call_w_done", {15'b0, exec_valid_w}, 16'd0);
    // CPSE skipping a two-word STS
    feed(1'b1, 16'h1012);
    tick;
    skip_taken = 1'b1;
    feed(1'b1, 16'h9200);
    chk("cpse_exec", {15'b0, exec_valid}, 16'd1);
    chk("cpse_ready", {15'b0, fetch_ready}, 16'd0);
    tick;
    skip_taken = 1'b0;
    feed(1'b1, 16'h9200);
    chk("skip1_exec", {15'b0, exec_valid}, 16'd0);
    chk("skip1_pcinc", {15'b0, pc_inc}, 16'd1);
    tick;
    feed(1'b1, 16'h0100);
    chk("skip2_exec", {15'b0, exec_valid}, 16'd0);
    chk("skip2_pcinc", {15'b0, pc_inc}, 16'd1);
    chk("skip2_op", opcode, 16'h1012);
    tick;
    feed(1'b1, 16'h0C78);
    chk("skip_after_pcinc", {15'b0, pc_inc}, 16'd1);
    chk("skip_after_exec", {15'b0, exec_valid}, 16'd0);
    tick;
    feed(1'b0, 16'h0000);
    chk("post_skip_op", opcode, 16'h0C78);
    chk("post_skip_exec", {15'b0, exec_valid}, 16'd1);
    tick;
    // BREQ not taken then taken
    feed(1'b1, 16'hF001);
    tick;
    feed(1'b0, 16'h0000);
    chk("brnt_last", {15'b0, last_cycle}, 16'd1);
    chk("brnt_exec", {15'b0, exec_valid}, 16'd1);
    tick;
    chk("brnt_done", {15'b0, exec_valid}, 16'd0);
    feed(1'b1, 16'hF001);
    tick;
    branch_taken = 1'b1;
    feed(1'b0, 16'h0000);
    chk("brt_c0_last", {15'b0, last_cycle}, 16'd0);
    chk("brt_c0_ready", {15'b0, fetch_ready}, 16'd0);
    tick;
    branch_taken = 1'b0;
    #1;
    chk("brt_c1_cyc", {13'b0, cycle}, 16'd1);
    chk("brt_c1_last", {15'b0, last_cycle}, 16'd1);
    chk("brt_c1_ready", {15'b0, fetch_ready}, 16'd0);
    tick;
    chk("brt_done", {15'b0, exec_valid}, 16'd0);
    chk("brt_ready", {15'b0, fetch_ready}, 16'd1);
    // RET with a three-clock stall on cycle 1
    feed(1'b1, 16'h9508);
    tick;
    feed(1'b0, 16'h0000);
    tick;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ret_stall_cyc", {13'b0, cycle}, 16'd1);
      chk("ret_stall_exec", {15'b0, exec_valid}, 16'd1);
      chk("ret_stall_ready", {15'b0, fetch_ready}, 16'd0);
      tick;
    end
    stall = 1'b0;
    #1;
    chk("ret_c1", {13'b0, cycle}, 16'd1);
    tick;
    chk("ret_c2", {13'b0, cycle}, 16'd2);
    tick;
    chk("ret_c3", {13'b0, cycle}, 16'd3);
    chk("ret_c3_last", {15'b0, last_cycle}, 16'd1);
    chk("ret_w_c3_last", {15'b0, last_cycle_w}, 16'd0);
    tick;
    chk("ret_done", {15'b0, exec_valid}, 16'd0);
    chk("ret_w_c4", {13'b0, cycle_w}, 16'd4);
    tick;
    // reset mid-LPM
    feed(1'b1, 16'h95C8);
    tick;
    feed(1'b0, 16'h0000);
    tick; tick;
    chk("lpm_c2", {13'b0, cycle}, 16'd2);
    rst_n = 1'b0;
    #1;
    chk("lpm_rst_op", opcode, 16'h0000);
    chk("lpm_rst_cyc", {13'b0, cycle}, 16'd0);
    chk("lpm_rst_exec", {15'b0, exec_valid}, 16'd0);
    chk("lpm_rst_ready", {15'b0, fetch_ready}, 16'd1);
    tick;
    rst_n = 1'b1;
    feed(1'b1, 16'h0C9A);
    tick;
    feed(1'b0, 16'h0000);
    chk("post_rst_op", opcode, 16'h0C9A);
    chk("post_rst_cyc", {13'b0, cycle}, 16'd0);
    chk("post_rst_exec", {15'b0, exec_valid}, 16'd1);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
